// File: rtl/tbird_pkg.sv
// ---------------------------------------------------------------------------
// tbird_pkg : shared mode encoding and thermometer helper for tbird_seq
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tbird_pkg;

  localparam int c_mode_w    = 2;
  localparam int c_max_lamps = 16;

  typedef enum logic [c_mode_w-1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  // Lowest n bits set; n may reach c_max_lamps, hence the one-bit-wider intermediate.
  function automatic logic [c_max_lamps-1:0] therm(input logic [4:0] n);
    logic [c_max_lamps:0] t;
    t = ((c_max_lamps+1)'(1) << n) - (c_max_lamps+1)'(1);
    return t[c_max_lamps-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tbird_prescaler.sv
// ---------------------------------------------------------------------------
// tbird_prescaler : free-running 0..TICK_DIV-1 counter, tick on terminal count
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tbird_prescaler #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int c_cw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

  logic [c_cw-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tbird_seq.sv
// ---------------------------------------------------------------------------
// tbird_seq : Thunderbird tail-lamp sequencer (left/right/hazard, optional
//             brake override enabled by TBIRD_BRAKE_EN)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tbird_seq
  import tbird_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_req,
  input  logic                right_req,
  input  logic                hazard_req,
  input  logic                brake,
  output logic [LAMPS-1:0]    lamps_l,
  output logic [LAMPS-1:0]    lamps_r,
  output logic [c_mode_w-1:0] mode,
  output logic                busy
);

  localparam int c_sw = $clog2(LAMPS + 1);
  localparam logic [c_sw-1:0] c_last = c_sw'(LAMPS);

  logic             w_tick;
  logic             w_brake_on;
  mode_e            r_mode;
  mode_e            w_mode_nx;
  logic [c_sw-1:0]  r_step;
  logic [c_sw-1:0]  w_step_nx;
  logic [LAMPS-1:0] w_therm;
  logic [LAMPS-1:0] w_l_nx;
  logic [LAMPS-1:0] w_r_nx;
  logic [LAMPS-1:0] r_lamps_l;
  logic [LAMPS-1:0] r_lamps_r;
  logic             r_busy;

  tbird_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

`ifdef TBIRD_BRAKE_EN
  assign w_brake_on = brake;
`else
  logic w_unused_brake;
  assign w_unused_brake = brake;
  assign w_brake_on     = 1'b0;
`endif

  // Requests are only looked at when leaving IDLE; running sequences always finish.
  always_comb begin
    w_mode_nx = r_mode;
    w_step_nx = r_step;
    if (w_tick) begin
      case (r_mode)
        MODE_IDLE: begin
          if (hazard_req || (left_req && right_req)) begin
            w_mode_nx = MODE_HAZARD;
            w_step_nx = c_sw'(1);
          end else if (left_req) begin
            w_mode_nx = MODE_LEFT;
            w_step_nx = c_sw'(1);
          end else if (right_req) begin
            w_mode_nx = MODE_RIGHT;
            w_step_nx = c_sw'(1);
          end
        end
        MODE_LEFT, MODE_RIGHT: begin
          if (r_step == c_last) begin
            w_mode_nx = MODE_IDLE;
            w_step_nx = '0;
          end else begin
            w_step_nx = r_step + c_sw'(1);
          end
        end
        default: begin
          w_mode_nx = MODE_IDLE;
          w_step_nx = '0;
        end
      endcase
    end
  end

  assign w_therm = LAMPS'(therm(5'(w_step_nx)));

  always_comb begin
    w_l_nx = '0;
    w_r_nx = '0;
    case (w_mode_nx)
      MODE_LEFT:   w_l_nx = w_therm;
      MODE_RIGHT:  w_r_nx = w_therm;
      MODE_HAZARD: begin
        w_l_nx = '1;
        w_r_nx = '1;
      end
      default: ;
    endcase
    // Brake lights whichever bank is not turning; the hazard flash takes precedence.
    if (w_brake_on && (w_mode_nx != MODE_HAZARD)) begin
      if (w_mode_nx != MODE_LEFT)  w_l_nx = '1;
      if (w_mode_nx != MODE_RIGHT) w_r_nx = '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= MODE_IDLE;
      r_step    <= '0;
      r_lamps_l <= '0;
      r_lamps_r <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_mode    <= w_mode_nx;
      r_step    <= w_step_nx;
      r_lamps_l <= w_l_nx;
      r_lamps_r <= w_r_nx;
      r_busy    <= (w_mode_nx != MODE_IDLE);
    end
  end

  assign lamps_l = r_lamps_l;
  assign lamps_r = r_lamps_r;
  assign mode    = r_mode;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tbird_seq.sv
// ---------------------------------------------------------------------------
// tb_tbird_seq : self-checking bench for tbird_seq (LAMPS=3, TICK_DIV=2)
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tbird_seq;

  localparam int LAMPS    = 3;
  localparam int TICK_DIV = 2;

  typedef struct packed {
    logic [LAMPS-1:0] l;
    logic [LAMPS-1:0] r;
    logic [1:0]       mode;
    logic             busy;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             left_req;
  logic             right_req;
  logic             hazard_req;
  logic             brake;
  logic [LAMPS-1:0] lamps_l;
  logic [LAMPS-1:0] lamps_r;
  logic [1:0]       mode;
  logic             busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  int         m_cnt  = 0;
  int         m_step = 0;
  logic [1:0] m_mode = 2'd0;

  tbird_seq #(
    .LAMPS    (LAMPS),
    .TICK_DIV (TICK_DIV)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .brake      (brake),
    .lamps_l    (lamps_l),
    .lamps_r    (lamps_r),
    .mode       (mode),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: advance on each edge, push the expectation, compare just after.
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    bit   tk;
    if (!reset) begin
      m_cnt  = 0;
      m_step = 0;
      m_mode = 2'd0;
    end else begin
      tk    = (m_cnt == TICK_DIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        if (m_mode == 2'd0) begin
          if (hazard_req || (left_req && right_req)) begin m_mode = 2'd3; m_step = 1; end
          else if (left_req)  begin m_mode = 2'd1; m_step = 1; end
          else if (right_req) begin m_mode = 2'd2; m_step = 1; end
        end else if (m_mode == 2'd3 || m_step == LAMPS) begin
          m_mode = 2'd0;
          m_step = 0;
        end else begin
          m_step = m_step + 1;
        end
      end
    end
    e.l = '0;
    e.r = '0;
    if (reset) begin
      if (m_mode == 2'd1) e.l = LAMPS'((1 << m_step) - 1);
      if (m_mode == 2'd2) e.r = LAMPS'((1 << m_step) - 1);
      if (m_mode == 2'd3) begin e.l = '1; e.r = '1; end
`ifdef TBIRD_BRAKE_EN
      if (brake && m_mode != 2'd3) begin
        if (m_mode != 2'd1) e.l = '1;
        if (m_mode != 2'd2) e.r = '1;
      end
`endif
    end
    e.mode = m_mode;
    e.busy = (m_mode != 2'd0);
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      got = sb_q.pop_front();
      check("sb_lamps_l", 32'(lamps_l), 32'(got.l));
      check("sb_lamps_r", 32'(lamps_r), 32'(got.r));
      check("sb_mode",    32'(mode),    32'(got.mode));
      check("sb_busy",    32'(busy),    32'(got.busy));
    end
  end

  initial begin
    logic [LAMPS-1:0] seq_l [4];
    logic [LAMPS-1:0] cur;
    int d;
    seq_l[0] = 3'b011; seq_l[1] = 3'b111; seq_l[2] = 3'b000; seq_l[3] = 3'b001;

    reset = 1'b0; left_req = 1'b1; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_lamps_l", 32'(lamps_l), 32'(0));
    check("rst_lamps_r", 32'(lamps_r), 32'(0));
    check("rst_mode",    32'(mode),    32'(0));
    check("rst_busy",    32'(busy),    32'(0));
    reset = 1'b1;

    // Held left request: 001,011,111,000,001 with two cycles each
    for (int i = 0; i < 10 && lamps_l != 3'b001; i++) @(negedge clk);
    check("left_first", 32'(lamps_l), 32'(3'b001));
    check("left_mode",  32'(mode),    32'(1));
    cur = 3'b001;
    for (int k = 0; k < 4; k++) begin
      d = 0;
      while (lamps_l == cur && d < 10) begin
        @(negedge clk);
        d++;
      end
      check("left_dur", 32'(d), 32'(2));
      check("left_seq", 32'(lamps_l), 32'(seq_l[k]));
      check("left_r_off", 32'(lamps_r), 32'(0));
      cur = seq_l[k];
    end
    left_req = 1'b0;
    for (int i = 0; i < 20 && mode != 2'd0; i++) @(negedge clk);
    check("left_done", 32'(mode), 32'(0));

    // Right request held for a single tick
    right_req = 1'b1;
    for (int i = 0; i < 10 && mode != 2'd2; i++) @(negedge clk);
    right_req = 1'b0;
    check("right_start", 32'(lamps_r), 32'(3'b001));
    repeat (12) @(negedge clk);
    check("right_idle_r",    32'(lamps_r), 32'(0));
    check("right_idle_mode", 32'(mode),    32'(0));

    // Both turn requests together act as hazard
    left_req = 1'b1; right_req = 1'b1;
    for (int i = 0; i < 10 && mode != 2'd3; i++) @(negedge clk);
    check("haz_on_l", 32'(lamps_l), 32'(3'b111));
    check("haz_on_r", 32'(lamps_r), 32'(3'b111));
    repeat (2) @(negedge clk);
    check("haz_off_l",    32'(lamps_l), 32'(0));
    check("haz_off_mode", 32'(mode),    32'(0));
    repeat (2) @(negedge clk);
    check("haz_again_r",    32'(lamps_r), 32'(3'b111));
    check("haz_again_mode", 32'(mode),    32'(3));
    left_req = 1'b0; right_req = 1'b0;
    for (int i = 0; i < 10 && mode != 2'd0; i++) @(negedge clk);

    // Switch left to right mid-sequence: left completes first
    left_req = 1'b1;
    for (int i = 0; i < 20 && lamps_l != 3'b011; i++) @(negedge clk);
    left_req = 1'b0; right_req = 1'b1;
    for (int i = 0; i < 10 && lamps_l != 3'b111; i++) @(negedge clk);
    check("sw_l_full", 32'(lamps_l), 32'(3'b111));
    for (int i = 0; i < 10 && lamps_l == 3'b111; i++) @(negedge clk);
    check("sw_gap_l", 32'(lamps_l), 32'(0));
    check("sw_gap_r", 32'(lamps_r), 32'(0));
    for (int i = 0; i < 10 && lamps_r != 3'b001; i++) @(negedge clk);
    check("sw_r_start", 32'(lamps_r), 32'(3'b001));
    check("sw_r_mode",  32'(mode),    32'(2));
    right_req = 1'b0;
    for (int i = 0; i < 20 && mode != 2'd0; i++) @(negedge clk);

    // Asynchronous reset in the middle of a sequence
    left_req = 1'b1;
    for (int i = 0; i < 20 && lamps_l != 3'b011; i++) @(negedge clk);
    check("ar_pre", 32'(lamps_l), 32'(3'b011));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_lamps_l", 32'(lamps_l), 32'(0));
    check("ar_mode",    32'(mode),    32'(0));
    check("ar_busy",    32'(busy),    32'(0));
    left_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Brake with left turn
    left_req = 1'b1; brake = 1'b1;
    for (int i = 0; i < 10 && lamps_l != 3'b001; i++) @(negedge clk);
    check("brk_l_seq", 32'(lamps_l), 32'(3'b001));
`ifdef TBIRD_BRAKE_EN
    check("brk_r_on", 32'(lamps_r), 32'(3'b111));
    repeat (3) @(negedge clk);
    check("brk_r_on2", 32'(lamps_r), 32'(3'b111));
`else
    check("brk_r_off", 32'(lamps_r), 32'(0));
    repeat (3) @(negedge clk);
    check("brk_r_off2", 32'(lamps_r), 32'(0));
`endif
    left_req = 1'b0; brake = 1'b0;
    for (int i = 0; i < 20 && mode != 2'd0; i++) @(negedge clk);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tbird_seq.md
# tbird_seq

Parametrised Thunderbird tail-lamp sequencer: drives two banks of LAMPS lamps (left, right) with running-thermometer turn sequences and a both-sides hazard flash, stepping on a prescaled tick. It is the next-generation replacement for the fixed three-lamp, two-flip-flop side sequencer. It sits between the switch/key inputs and the LEDR lamp outputs on the board top level.

## Interface
- LAMPS, 3: lamps per side; legal range 2..16.
- TICK_DIV, 2: clk cycles per sequencer step; 1 means step every cycle.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- left_req  in  1  left-turn request, level-sensitive.
- right_req  in  1  right-turn request, level-sensitive.
- hazard_req  in  1  hazard request, level-sensitive.
- brake  in  1  brake pedal; used only when TBIRD_BRAKE_EN is defined, ignored otherwise.
- lamps_l  out  LAMPS  left bank; bit 0 is innermost.
- lamps_r  out  LAMPS  right bank; bit 0 is innermost.
- mode  out  2  active sequence: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- busy  out  1  high whenever mode != IDLE.

## Operation
- Prescaler: counter 0..TICK_DIV-1, width $clog2(TICK_DIV) (minimum 1). A tick is asserted in the cycle where the count is TICK_DIV-1. The counter wraps to 0 and runs freely from reset.
- State: mode register (2 bits) and step register (0..LAMPS, width $clog2(LAMPS+1)). IDLE is equivalent to step 0.
- On a tick in IDLE, requests are sampled and resolved in priority order:
  - hazard_req, or left_req and right_req together, starts HAZARD.
  - left_req alone starts LEFT.
  - right_req alone starts RIGHT.
  - No request leaves the block in IDLE.
- A started sequence sets step to 1.
- LEFT/RIGHT: each tick increments step. At step LAMPS, the next tick returns to step 0 and IDLE.
- The active bank shows a thermometer of step lamps: (1<<step)-1, so with LAMPS=3 the pattern is 001, 011, 111, 000. The other bank is 0.
- HAZARD: step 1 lights both banks fully. The next tick returns to step 0 and IDLE, which gives an alternating all-on/all-off flash while the request is held.
- Requests are ignored mid-sequence. A started sequence always completes, even if its request drops. A new or changed request takes effect only at the tick that leaves IDLE, so each pattern ends with exactly one all-off step.
- Lamp outputs are registered and computed from the next state, so they change on the same edge as step and mode.

## Timing
- Reset values: lamps_l=0, lamps_r=0, mode=0, busy=0, step=0, prescaler=0.
- Request to first lamp: 1 to TICK_DIV cycles, depending on prescaler phase. A request must be held across a tick to be seen.
- Each non-idle step lasts exactly TICK_DIV cycles. A LEFT/RIGHT period is (LAMPS+1)*TICK_DIV cycles; a HAZARD period is 2*TICK_DIV cycles.
- Reset asserted mid-sequence clears all outputs asynchronously. After release, the prescaler restarts at 0.
- Brake (when enabled) has 1-cycle latency and is independent of the tick.

## Configuration
- TBIRD_BRAKE_EN defined: when brake is high, every bank not showing a turn pattern is forced to all-ones.
  - IDLE: both banks on.
  - LEFT: lamps_r all on; lamps_l unaffected.
  - RIGHT: lamps_l all on; lamps_r unaffected.
  - HAZARD: no effect; the flash wins.
- TBIRD_BRAKE_EN undefined: brake is ignored, and the outputs are identical to the brake=0 behaviour.

## Structure
- tbird_pkg holds:
  - the mode enum (MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZARD);
  - the 2-bit mode width constant;
  - a thermometer helper function.
- Sub-module tbird_prescaler (TICK_DIV parameter; ports clk, reset, tick). The sequencer FSM and output registers stay in tbird_seq.

## Test plan
All scenarios use LAMPS=3, TICK_DIV=2.
- Reset low: lamps_l=000, lamps_r=000, mode=0, busy=0. Hold left_req during reset: outputs stay 0.
- Hold left_req: lamps_l cycles 001, 011, 111, 000, 001, each value lasting 2 cycles; lamps_r=000; mode=1 while lit.
- Assert right_req for one tick only: lamps_r shows 001, 011, 111, 000, then stays 000 with mode=0.
- Assert left_req and right_req together: both banks show 111 then 000, alternating every 2 cycles; mode=3.
- Hold left_req, switch to right_req at step 2: lamps_l completes 111 then 000, then lamps_r starts at 001. Separately, pull reset low at step 2: all outputs become 0 without waiting for a clock edge.
- TBIRD_BRAKE_EN defined, left_req plus brake: lamps_r=111 while lamps_l sequences. Same stimulus without the macro: lamps_r=000.
